char_bank_writer: RTL
=====================

CHAR_BANK_WRITER -- requirements
Module: char_bank_writer

Interface
REQ-001 SHALL have parameter SCROLL_DIV, default 25000000, meaning the number of clock cycles per scroll step (legal range 2 to 2^26-1).
REQ-002 SHALL have port CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port WR_DATA  input  2  character code to be written.
REQ-005 SHALL have port WR_ADDR  input  2  target slot index, 0..3.
REQ-006 SHALL have port WR_STB  input  1  write strobe, active-high level; only its rising edge requests a write.
REQ-007 SHALL have port SCROLL_EN  input  1  enables periodic rotation of the bank.
REQ-008 SHALL have port BANK  output  8  packed character slots; slot k occupies bits [2k+1:2k].
REQ-009 SHALL have port WR_ACK  output  1  one-cycle pulse confirming a completed write.
REQ-010 SHALL have port SCROLL_TICK  output  1  one-cycle pulse marking a rotation.

Function
REQ-011 SHALL register WR_STB into stb_q every cycle.
REQ-012 SHALL define a write event as a cycle with WR_STB=1 and stb_q=0, giving exactly one write per rising edge regardless of how long the strobe is held.
REQ-013 SHALL, on a write event, load WR_DATA into slot WR_ADDR of BANK at that same clock edge and leave the other three slots unchanged.
REQ-014 SHALL assert WR_ACK for exactly the one cycle following the write edge (a registered pulse, latency 1).
REQ-015 SHALL, while SCROLL_EN=1, run a prescaler 0..SCROLL_DIV-1 that wraps to 0 at terminal count.
REQ-016 SHALL, on the edge where the prescaler wraps, rotate BANK left by one slot: new slot0 = old slot3, new slot k = old slot k-1.
REQ-017 SHALL assert SCROLL_TICK for exactly the one cycle following each rotation.
REQ-018 SHALL, while SCROLL_EN=0, clear the prescaler to 0 and hold it there, with no rotation and no SCROLL_TICK.
REQ-019 SHALL, when a write event and a rotation fall on the same edge, apply the rotation first and then overwrite slot WR_ADDR of the rotated bank, so the write wins its slot; WR_ACK and SCROLL_TICK both pulse on the next cycle.
REQ-020 SHALL ignore WR_ADDR and WR_DATA on all cycles without a write event.
REQ-021 SHALL drive BANK directly from a register, with no combinational path from the inputs.

Reset
REQ-022 SHALL, on a clock edge with RST=1, set BANK=8'hE4 (slot k holds code k), clear the prescaler, and drive WR_ACK=0 and SCROLL_TICK=0.
REQ-023 SHALL, on a clock edge with RST=1, set stb_q=1 so that a strobe held through reset release produces no write.
REQ-024 SHALL give RST priority over a write event or a rotation on the same edge, and SHALL abort any partial prescaler count.

Structure
REQ-025 SHALL take the character-code constants CH_0..CH_3, the reset value RESET_BANK=8'hE4 and the prescaler width from a shared package used by the display decoder and the slot multiplexer.
REQ-026 SHALL instantiate the strobe edge detector as the sub-module rise_detect (ports: clock, reset, level in, pulse out, with reset preloading the history to 1).
REQ-027 SHALL keep the prescaler and the bank update in this module; the total RTL SHALL be at most 400 lines.

Verification
REQ-028 SHALL test reset: assert RST for 2 cycles -> BANK=8'hE4, WR_ACK=0 and SCROLL_TICK=0.
REQ-029 SHALL test a single write: WR_ADDR=2, WR_DATA=0, WR_STB held high for 10 cycles -> BANK=8'hC4 after the edge, exactly one WR_ACK pulse.
REQ-030 SHALL test scrolling: SCROLL_DIV=4, SCROLL_EN=1 from reset -> BANK=8'h93 after 4 cycles, 8'h4E after 8 cycles, and one SCROLL_TICK per 4 cycles.
REQ-031 SHALL test write and rotation on the same edge: SCROLL_DIV=4, write WR_ADDR=0, WR_DATA=2 timed on the wrap edge -> BANK=8'h92, WR_ACK and SCROLL_TICK both pulse.
REQ-032 SHALL test a strobe held through reset: WR_STB=1 during RST and after release -> BANK stays 8'hE4 and no WR_ACK.
REQ-033 SHALL test scroll pause: drop SCROLL_EN mid-count for 3 cycles, then re-raise it -> the next rotation occurs SCROLL_DIV cycles after the re-enable.

Source files
------------

// File: rtl/char_bank_writer_pkg.sv
// Shared definitions for the character bank: character codes, reset image of the
// bank, prescaler width and slot helpers. Also used by the display decoder and
// the slot multiplexer.
package char_bank_writer_pkg;

  localparam int unsigned PRESCALE_W = 26;

  localparam logic [1:0] CH_0 = 2'd0;
  localparam logic [1:0] CH_1 = 2'd1;
  localparam logic [1:0] CH_2 = 2'd2;
  localparam logic [1:0] CH_3 = 2'd3;

  // Slot k holds code k; slot 0 is the least significant pair.
  localparam logic [7:0] RESET_BANK = {CH_3, CH_2, CH_1, CH_0};

  // Rotate left by one slot: slot0 <- slot3, slot k <- slot k-1.
  function automatic logic [7:0] rotate_slots(input logic [7:0] bank);
    return {bank[5:0], bank[7:6]};
  endfunction

  // Replace one slot, leaving the other three untouched.
  function automatic logic [7:0] put_slot(input logic [7:0] bank,
                                          input logic [1:0] addr,
                                          input logic [1:0] data);
    logic [7:0] r;
    r = bank;
    r[{addr, 1'b0} +: 2] = data;
    return r;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level signal.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset; preloads the history to 1 so a
//             level already high at reset release gives no pulse
//   level_i - level input
//   pulse_o - high in the cycle where level_i is 1 and was 0 the cycle before
module rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic stb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_q <= 1'b1;
    end else begin
      stb_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~stb_q;

endmodule

// File: rtl/char_bank_writer.sv
// Four-slot character bank with edge-triggered writes and periodic rotation.
// Ports:
//   CLOCK_50    - system clock
//   RST         - synchronous active-high reset
//   WR_DATA     - character code to write
//   WR_ADDR     - target slot 0..3
//   WR_STB      - write strobe level; each rising edge writes once
//   SCROLL_EN   - enables the rotation prescaler
//   BANK        - packed slots, slot k at [2k+1:2k], registered
//   WR_ACK      - one-cycle pulse after each write
//   SCROLL_TICK - one-cycle pulse after each rotation
module char_bank_writer
  import char_bank_writer_pkg::*;
#(
  parameter int unsigned SCROLL_DIV = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic [1:0] WR_DATA,
  input  logic [1:0] WR_ADDR,
  input  logic       WR_STB,
  input  logic       SCROLL_EN,
  output logic [7:0] BANK,
  output logic       WR_ACK,
  output logic       SCROLL_TICK
);

  localparam logic [PRESCALE_W-1:0] PrescTerm = PRESCALE_W'(SCROLL_DIV - 1);

  logic                  wr_event;
  logic                  scroll_wrap;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [7:0]            bank_q, bank_d;
  logic                  ack_q, tick_q;

  rise_detect u_rise_detect (
    .clk_i   (CLOCK_50),
    .rst_i   (RST),
    .level_i (WR_STB),
    .pulse_o (wr_event)
  );

  always_comb begin
    scroll_wrap = SCROLL_EN && (presc_q == PrescTerm);

    if (!SCROLL_EN || scroll_wrap) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // Rotation is applied first so a coincident write owns its slot.
    bank_d = bank_q;
    if (scroll_wrap) begin
      bank_d = rotate_slots(bank_d);
    end
    if (wr_event) begin
      bank_d = put_slot(bank_d, WR_ADDR, WR_DATA);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      bank_q  <= RESET_BANK;
      presc_q <= '0;
      ack_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      presc_q <= presc_d;
      ack_q   <= wr_event;
      tick_q  <= scroll_wrap;
    end
  end

  assign BANK        = bank_q;
  assign WR_ACK      = ack_q;
  assign SCROLL_TICK = tick_q;

endmodule
